// File: rtl/decode_issue_queue.sv
// ----------------------------------------------------------------------------
// decode_issue_queue
//
// FIFO between the instruction decoder and the register-read stage. It holds
// fully decoded instruction bundles and exchanges them over valid/ready
// handshakes. It decouples decode from register-read stalls and can discard
// all queued bundles on a branch-redirect flush. The bundle contents are
// opaque to this block.
//
// Ports
//   clock_i      in   1            sole clock, rising edge
//   resset_i     in   1            synchronous active-high reset
//   flush_i      in   1            discard all queued entries (synchronous)
//   in_valid_i   in   1            decoder presents a bundle
//   in_ready_o   out  1            queue accepts a bundle this cycle
//   in_bundle_i  in   bundleWidth  decoded bundle from the decoder
//   out_valid_o  out  1            head bundle valid for register-read
//   out_ready_i  in   1            register-read takes the head this cycle
//   out_bundle_o out  bundleWidth  head bundle
//   count_o      out  ptrWidth+1   current occupancy, 0..depth
//
// Configuration macro
//   DECODE_QUEUE_BYPASS_EN : when the queue is empty and both sides handshake
//   with no flush, in_bundle_i passes straight to out_bundle_o in the same
//   cycle and is not stored. Undefined: minimum latency is one cycle.
// ----------------------------------------------------------------------------
module decode_issue_queue #(
    parameter int depth       = 4,
    parameter int ptrWidth    = 2,
    parameter int bundleWidth = 133
) (
    input  logic                   clock_i,
    input  logic                   resset_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [bundleWidth-1:0] in_bundle_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [bundleWidth-1:0] out_bundle_o,
    output logic [ptrWidth:0]      count_o
);

    localparam logic [ptrWidth:0]   full_count = (ptrWidth + 1)'(depth);
    localparam logic [ptrWidth-1:0] ptr_one    = ptrWidth'(1);

    logic [bundleWidth-1:0] storage [depth];
    logic [ptrWidth-1:0]    wr_ptr;
    logic [ptrWidth-1:0]    rd_ptr;
    logic [ptrWidth:0]      count;

    logic push;
    logic pop;
    logic bypass;
    logic do_write;
    logic do_read;

    // Full blocks new input even when a pop happens in the same cycle; this
    // keeps in_ready_o independent of out_ready_i.
    assign in_ready_o = !resset_i && (count != full_count);

`ifdef DECODE_QUEUE_BYPASS_EN
    // Empty queue with both sides handshaking: forward the incoming bundle
    // directly, leaving storage and pointers untouched.
    assign bypass = !resset_i && !flush_i && (count == '0) && in_valid_i && out_ready_i;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid_o  = (count != '0) || bypass;
        out_bundle_o = bypass ? in_bundle_i : storage[rd_ptr];
    end

    assign push     = in_valid_i && in_ready_o;
    assign pop      = out_valid_o && out_ready_i;
    assign do_write = push && !bypass;
    assign do_read  = pop && !bypass;
    assign count_o  = count;

    always_ff @(posedge clock_i) begin
        if (resset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset so out_bundle_o reads zero
            // afterwards; flush deliberately leaves the contents alone.
            for (int i = 0; i < depth; i++) begin
                storage[i] <= '0;
            end
        end else if (flush_i) begin
            // A same-cycle pop has already been handed to the consumer; a
            // same-cycle push is simply dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                storage[wr_ptr] <= in_bundle_i;
                wr_ptr          <= wr_ptr + ptr_one;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
